// File: rtl/einstein_kbd_matrix.sv
// einstein_kbd_matrix: PS/2 set-2 key events -> Einstein 8x8 keyboard matrix, modifier lines and row-scan port
//   clk_sys   : system clock
//   reset     : asynchronous, active-high
//   ps2_key   : {toggle, make, e0, scancode[7:0]} from mist_io
//   addr      : row select, active-low (several rows may be selected)
//   kb_cols   : column data of the selected rows, active-low, registered
//   modif     : {ctrl, graph, shift}, active-high
//   press_btn : high while at least one matrix key is held, registered
// Optional build macro KBD_KEYPAD_EN: keypad digits and keypad enter alias the main-row keys.
module einstein_kbd_matrix #(
  parameter int DEBOUNCE_EVT = 0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [10:0] ps2_key,
  input  logic [7:0]  addr,
  output logic [7:0]  kb_cols,
  output logic [2:0]  modif,
  output logic        press_btn
);
  logic [10:0] r_key_q;
  logic        r_tog_prev;
  logic [1:0]  r_vld;
  logic [63:0] r_matrix;
  logic [7:0]  r_src;
  logic [6:0]  r_held;
  logic [7:0]  r_cols;
  logic        r_press;
  logic [7:0]  w_lu;
  logic [7:0]  w_rowor;
  logic        w_evt, w_make, w_is_key, w_is_mod, w_cur, w_skip, w_apply;
  logic [5:0]  w_idx;
  logic [2:0]  w_src;

  // Lookup result: {2'b01, row, col} for a matrix key, {2'b10, 3'b0, source} for a modifier
  // source (0/1 L/R shift, 2/3 L/R ctrl, 4/5 L/R graph), 0 for an unmapped code.
  function automatic logic [7:0] lookup(input logic [8:0] k);
    logic [7:0] lu;
    lu = 8'h00;
    case (k)
      9'h029: lu = {2'b01, 3'd0, 3'd0};
      9'h01A: lu = {2'b01, 3'd0, 3'd1};
      9'h022: lu = {2'b01, 3'd0, 3'd2};
      9'h021: lu = {2'b01, 3'd0, 3'd3};
      9'h02A: lu = {2'b01, 3'd0, 3'd4};
      9'h032: lu = {2'b01, 3'd0, 3'd5};
      9'h031: lu = {2'b01, 3'd0, 3'd6};
      9'h03A: lu = {2'b01, 3'd0, 3'd7};
      9'h015: lu = {2'b01, 3'd1, 3'd0};
      9'h01D: lu = {2'b01, 3'd1, 3'd1};
      9'h024: lu = {2'b01, 3'd1, 3'd2};
      9'h02D: lu = {2'b01, 3'd1, 3'd3};
      9'h02C: lu = {2'b01, 3'd1, 3'd4};
      9'h035: lu = {2'b01, 3'd1, 3'd5};
      9'h03C: lu = {2'b01, 3'd1, 3'd6};
      9'h05A: lu = {2'b01, 3'd1, 3'd7};
      9'h043: lu = {2'b01, 3'd2, 3'd0};
      9'h044: lu = {2'b01, 3'd2, 3'd1};
      9'h04D: lu = {2'b01, 3'd2, 3'd2};
      9'h175: lu = {2'b01, 3'd2, 3'd3};
      9'h172: lu = {2'b01, 3'd2, 3'd4};
      9'h16B: lu = {2'b01, 3'd2, 3'd5};
      9'h174: lu = {2'b01, 3'd2, 3'd6};
      9'h076: lu = {2'b01, 3'd2, 3'd7};
      9'h01B: lu = {2'b01, 3'd3, 3'd0};
      9'h023: lu = {2'b01, 3'd3, 3'd1};
      9'h02B: lu = {2'b01, 3'd3, 3'd2};
      9'h034: lu = {2'b01, 3'd3, 3'd3};
      9'h033: lu = {2'b01, 3'd3, 3'd4};
      9'h01C: lu = {2'b01, 3'd3, 3'd5};
      9'h03B: lu = {2'b01, 3'd3, 3'd6};
      9'h042: lu = {2'b01, 3'd3, 3'd7};
      9'h04B: lu = {2'b01, 3'd4, 3'd0};
      9'h04C: lu = {2'b01, 3'd4, 3'd1};
      9'h052: lu = {2'b01, 3'd4, 3'd2};
      9'h041: lu = {2'b01, 3'd4, 3'd3};
      9'h049: lu = {2'b01, 3'd4, 3'd4};
      9'h04A: lu = {2'b01, 3'd4, 3'd5};
      9'h066: lu = {2'b01, 3'd4, 3'd6};
      9'h00D: lu = {2'b01, 3'd4, 3'd7};
      9'h005: lu = {2'b01, 3'd5, 3'd0};
      9'h006: lu = {2'b01, 3'd5, 3'd1};
      9'h004: lu = {2'b01, 3'd5, 3'd2};
      9'h00C: lu = {2'b01, 3'd5, 3'd3};
      9'h04E: lu = {2'b01, 3'd5, 3'd4};
      9'h055: lu = {2'b01, 3'd5, 3'd5};
      9'h054: lu = {2'b01, 3'd5, 3'd6};
      9'h05B: lu = {2'b01, 3'd5, 3'd7};
      9'h03E: lu = {2'b01, 3'd6, 3'd0};
      9'h046: lu = {2'b01, 3'd6, 3'd1};
      9'h003: lu = {2'b01, 3'd6, 3'd2};
      9'h00B: lu = {2'b01, 3'd6, 3'd3};
      9'h083: lu = {2'b01, 3'd6, 3'd4};
      9'h00A: lu = {2'b01, 3'd6, 3'd5};
      9'h058: lu = {2'b01, 3'd6, 3'd6};
      9'h05D: lu = {2'b01, 3'd6, 3'd7};
      9'h045: lu = {2'b01, 3'd7, 3'd0};
      9'h016: lu = {2'b01, 3'd7, 3'd1};
      9'h01E: lu = {2'b01, 3'd7, 3'd2};
      9'h026: lu = {2'b01, 3'd7, 3'd3};
      9'h025: lu = {2'b01, 3'd7, 3'd4};
      9'h02E: lu = {2'b01, 3'd7, 3'd5};
      9'h036: lu = {2'b01, 3'd7, 3'd6};
      9'h03D: lu = {2'b01, 3'd7, 3'd7};
`ifdef KBD_KEYPAD_EN
      9'h069: lu = {2'b01, 3'd7, 3'd1};
      9'h072: lu = {2'b01, 3'd7, 3'd2};
      9'h07A: lu = {2'b01, 3'd7, 3'd3};
      9'h06B: lu = {2'b01, 3'd7, 3'd4};
      9'h073: lu = {2'b01, 3'd7, 3'd5};
      9'h074: lu = {2'b01, 3'd7, 3'd6};
      9'h06C: lu = {2'b01, 3'd7, 3'd7};
      9'h075: lu = {2'b01, 3'd6, 3'd0};
      9'h07D: lu = {2'b01, 3'd6, 3'd1};
      9'h070: lu = {2'b01, 3'd7, 3'd0};
      9'h15A: lu = {2'b01, 3'd1, 3'd7};
`endif
      9'h012: lu = {2'b10, 3'd0, 3'd0};
      9'h059: lu = {2'b10, 3'd0, 3'd1};
      9'h014: lu = {2'b10, 3'd0, 3'd2};
      9'h114: lu = {2'b10, 3'd0, 3'd3};
      9'h011: lu = {2'b10, 3'd0, 3'd4};
      9'h111: lu = {2'b10, 3'd0, 3'd5};
      default: lu = 8'h00;
    endcase
    return lu;
  endfunction

  // r_vld[1] only rises once r_tog_prev holds a post-reset sample, so a toggle
  // already sitting on ps2_key at reset release is never taken as an event.
  assign w_evt    = r_vld[1] & (r_key_q[10] ^ r_tog_prev);
  assign w_make   = r_key_q[9];
  assign w_lu     = lookup(r_key_q[8:0]);
  assign w_is_key = w_lu[7:6] == 2'b01;
  assign w_is_mod = w_lu[7:6] == 2'b10;
  assign w_idx    = w_lu[5:0];
  assign w_src    = w_lu[2:0];
  assign w_cur    = w_is_key ? r_matrix[w_idx] : r_src[w_src];
  assign w_skip   = (DEBOUNCE_EVT != 0) && w_make && w_cur;
  assign w_apply  = w_evt & ~w_skip;

  always_comb begin
    w_rowor = 8'h00;
    for (int r = 0; r < 8; r++) w_rowor = w_rowor | (addr[r] ? 8'h00 : r_matrix[r*8 +: 8]);
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_key_q    <= '0;
      r_tog_prev <= 1'b0;
      r_vld      <= 2'b00;
      r_matrix   <= '0;
      r_src      <= '0;
      r_held     <= '0;
      r_cols     <= 8'hFF;
      r_press    <= 1'b0;
    end else begin
      r_key_q    <= ps2_key;
      r_tog_prev <= r_key_q[10];
      r_vld      <= {r_vld[0], 1'b1};
      if (w_apply && w_is_key) begin
        r_matrix[w_idx] <= w_make;
        if (w_make != w_cur) r_held <= w_make ? r_held + 7'd1 : r_held - 7'd1;
      end
      if (w_apply && w_is_mod) r_src[w_src] <= w_make;
      r_cols  <= ~w_rowor;
      r_press <= r_held != 7'd0;
    end
  end

  assign kb_cols   = r_cols;
  assign press_btn = r_press;
  assign modif     = {r_src[2] | r_src[3], r_src[4] | r_src[5], r_src[0] | r_src[1]};
endmodule
